// File: rtl/usb_tx_arbiter_if.sv
// Transmit-path bus shared between the USB low-speed packet generators
// and usb_tx_arbiter: per-generator request/OE/data/EOP in, start/grant/tx out.
interface usb_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] reqOE;
  logic [NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0] reqEop;
  logic [NUM_REQ-1:0] start;
  logic [NUM_REQ-1:0] grant;
  logic txOE;
  logic txBit;
  logic txEop;

  modport master (
    input  req, reqOE, reqData, reqEop,
    output start, grant, txOE, txBit, txEop
  );

  modport slave (
    output req, reqOE, reqData, reqEop,
    input  start, grant, txOE, txBit, txEop
  );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Low-speed USB transmit arbiter: turnaround, start, mux, inter-packet gap.
// Define USB_TX_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module usb_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int TURNAROUND_BITS = 2,
  parameter int START_TIMEOUT   = 8,
  parameter int GAP_BITS        = 2
) (
  input  logic             useClk,
  input  logic             reset,
  input  logic             checkData,
  input  logic             rxActive,
  usb_tx_arbiter_if.master bus,
  output logic             busy,
  output logic             timeoutErr
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [5:0] TURN_LAST = 6'(TURNAROUND_BITS - 1);
  localparam logic [5:0] TO_LAST   = 6'(START_TIMEOUT - 1);
  localparam logic [5:0] GAP_LAST  = 6'(GAP_BITS - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE, TURN, START, ACTIVE, GAP
  } state_t;

  state_t             state;
  logic [5:0]         cnt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] start;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      win_idx;

`ifdef USB_TX_ARB_ROUND_ROBIN_EN
  localparam logic [IW:0]   NR       = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  // Rotate so bit 0 is rr_ptr, take the lowest set bit, rotate back.
  always_comb begin
    rot = (bus.req >> rr_ptr)
        | (bus.req << (NR - {1'b0, rr_ptr}));
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    win_idx = (sum >= NR) ? IW'(sum - NR) : IW'(sum);
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[k]) win_idx = IW'(k);
    end
  end
`endif

  always_ff @(posedge useClk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= '0;
      start      <= '0;
      idx        <= '0;
      timeoutErr <= 1'b0;
`ifdef USB_TX_ARB_ROUND_ROBIN_EN
      rr_ptr     <= '0;
`endif
    end else if (checkData) begin
      start      <= '0;
      timeoutErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxActive && |bus.req) begin
            grant <= ONE << win_idx;
            idx   <= win_idx;
            cnt   <= '0;
            state <= TURN;
          end
        end
        TURN: begin
          if (!bus.req[idx]) begin
            grant <= '0;
            state <= IDLE;
          end else if (rxActive) begin
            cnt <= '0;
          end else if (cnt == TURN_LAST) begin
            start <= grant;
            cnt   <= '0;
            state <= START;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        START: begin
          if (bus.reqOE[idx]) begin
            state <= ACTIVE;
          end else if (cnt == TO_LAST) begin
            timeoutErr <= 1'b1;
            cnt        <= '0;
            state      <= GAP;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ACTIVE: begin
          if (!bus.reqOE[idx]) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            grant <= '0;
            state <= IDLE;
`ifdef USB_TX_ARB_ROUND_ROBIN_EN
            rr_ptr <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
`endif
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The line is only driven once the owner has answered its start pulse.
  logic active;
  assign active = (state == ACTIVE);

  assign bus.grant = grant;
  assign bus.start = start;
  assign bus.txOE  = active & bus.reqOE[idx];
  assign bus.txBit = active & bus.reqData[idx];
  assign bus.txEop = active & bus.reqEop[idx];
  assign busy      = (state != IDLE);
endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Shares the single USB low-speed transmit path (line bit, output enable, EOP request) between up to NUM_REQ packet-answer generators, such as the SET_ADDRESS zero-length data responder and the handshake and descriptor responders. The block picks one pending requester and enforces bus turnaround after host traffic. It then starts the winning generator and muxes its bit stream onto the transmitter. It owns the line until the generator drops its output enable, then enforces an inter-packet gap before the next grant.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TURNAROUND_BITS, 2: idle bit times required after rxActive falls before a start pulse, 1..15.
- START_TIMEOUT, 8: bit times to wait for the granted generator's OE, 1..63.
- GAP_BITS, 2: idle bit times after a packet ends before re-arbitration, 1..15.

Ports:
- useClk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- checkData, in, 1: bit-time strobe; all state advances only on cycles where it is 1.
- rxActive, in, 1: host packet in progress, so the bus is busy.
- req, in, NUM_REQ: level request per generator.
- reqOE, in, NUM_REQ: per-generator output enable.
- reqData, in, NUM_REQ: per-generator line bit.
- reqEop, in, NUM_REQ: per-generator EOP call.
- start, out, NUM_REQ: one-hot start pulse to the winning generator.
- grant, out, NUM_REQ: one-hot current owner, 0 when idle.
- txOE, out, 1: muxed OE.
- txBit, out, 1: muxed line bit.
- txEop, out, 1: muxed EOP call.
- busy, out, 1: state is not IDLE.
- timeoutErr, out, 1: high for one strobe period when the start timeout expires.

## Operation
- Reset, synchronous: state IDLE, counter 0, rrPtr 0, and start, grant, busy and timeoutErr all 0. txOE, txBit and txEop are 0 because grant is 0.
- Every transition is evaluated only when checkData=1. Registered outputs hold their value between strobes.
- **IDLE**
  - If rxActive=0 and req≠0, the arbiter latches the winner into grant, clears the counter and moves to TURN.
  - If rxActive=1, no grant is made.
- **TURN**
  - rxActive=1 clears the counter.
  - If req[w] drops, grant clears and the state returns to IDLE with no start pulse.
  - Otherwise the counter increments. When the counter reaches TURNAROUND_BITS-1, start[w] is set, the counter clears and the state moves to START.
- **START**
  - start[w] clears at the next strobe, so it lasts exactly one strobe period.
  - If reqOE[w]=1, the state moves to ACTIVE.
  - Otherwise the counter increments. When the counter reaches START_TIMEOUT-1, timeoutErr is set for one strobe period and the state moves to GAP.
- **ACTIVE**
  - txOE, txBit and txEop are combinational from reqOE[w], reqData[w] and reqEop[w], with zero latency.
  - When reqOE[w]=0 at a strobe, the counter clears and the state moves to GAP.
  - rxActive is ignored in this state.
- **GAP**
  - The counter increments. When it reaches GAP_BITS-1, grant clears, rrPtr becomes (w+1) mod NUM_REQ and the state returns to IDLE.
- Outputs of non-granted requesters never reach tx*. While grant=0, tx* are 0.
- Counters are 6 bits wide and never wrap, because every count ends at its terminal compare.
- Reset mid-packet forces IDLE immediately and drops txOE in the same cycle as the reset register update.

## Timing
- From IDLE grant to start: TURNAROUND_BITS strobes, provided rxActive stays 0.
- start is registered and rises one useClk after the strobe that ends TURN.
- Generators sample start on their next checkData strobe. Their OE is therefore expected at the second START strobe or later.
- Minimum spacing from the strobe where OE falls to the next grant is GAP_BITS+1 strobes, because the IDLE arbitration happens on its own strobe.
- Simultaneous events:
  - In IDLE, a req arriving together with rxActive=1 is not granted.
  - In TURN, a req drop takes precedence over the terminal count.

## Configuration
- USB_TX_ARB_ROUND_ROBIN_EN defined: the winner is the first set req bit at or after rrPtr, searching with wrap-around.
- Not defined: fixed priority, where the lowest set index wins. rrPtr is not implemented.

## Test plan
- NUM_REQ=4, req=0100, rxActive=0 -> grant=0100 at the first strobe. start=0100 for one strobe after 2 strobes. After the generator drives OE for 34 strobes, tx* mirror generator 2 and grant clears 2 strobes after OE falls.
- req=0110 held, round-robin enabled -> grants go 0010, 0100, 0010. With the macro off -> grants go 0010, 0010.
- rxActive pulsed high for 3 strobes during TURN -> start is delayed until 2 strobes after rxActive falls.
- Granted generator never raises OE -> timeoutErr=1 at the 8th START strobe, then GAP, then IDLE. tx* stay 0 throughout.
- req[w] drops during TURN -> no start pulse and grant=0 at the next strobe. reset=1 during ACTIVE -> all outputs are 0 at the next clock.
